// File: rtl/fpu_status_pkg.sv
// Shared definitions for the FPU status word unit.
// Holds the bit positions of the 16-bit status word
// {B,C3,TOP[2:0],C2,C1,C0,ES,SF,PE,UE,OE,ZE,DE,IE},
// the exception-field width, and a packed struct that overlays the word.
package fpu_status_pkg;

  localparam int unsigned EXC_W = 6;

  localparam int unsigned SW_IE     = 0;
  localparam int unsigned SW_DE     = 1;
  localparam int unsigned SW_ZE     = 2;
  localparam int unsigned SW_OE     = 3;
  localparam int unsigned SW_UE     = 4;
  localparam int unsigned SW_PE     = 5;
  localparam int unsigned SW_SF     = 6;
  localparam int unsigned SW_ES     = 7;
  localparam int unsigned SW_C0     = 8;
  localparam int unsigned SW_C1     = 9;
  localparam int unsigned SW_C2     = 10;
  localparam int unsigned SW_TOP_LO = 11;
  localparam int unsigned SW_C3     = 14;
  localparam int unsigned SW_B      = 15;

  // Field order is MSB first, so this packs to exactly the status word layout.
  typedef struct packed {
    logic             b;
    logic             c3;
    logic [2:0]       top;
    logic             c2;
    logic             c1;
    logic             c0;
    logic             es;
    logic             sf;
    logic [EXC_W-1:0] exc;   // {PE,UE,OE,ZE,DE,IE}
  } fpu_status_t;

endpackage

// File: rtl/fpu_status_word_unit.sv
// FPU status word register.
// Holds busy, condition codes, the stack TOP pointer, the stack-fault bit and the
// six sticky exception flags, and packs them into the 16-bit status word. ES is
// formed combinationally from the flags and the current exception masks; the
// interrupt request is ES registered once.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   instr_start, op_done      instruction begin / complete pulses (busy, flag merge)
//   exc_flags, stack_fault,
//   stack_ovf                 exception info sampled with op_done
//   cc_we, cc_in              condition code write {C3,C2,C1,C0}
//   push, pop                 TOP decrement / increment
//   fclex, finit              clear exceptions / full initialise
//   load_en, load_word        whole-word load (FLDENV/FRSTOR)
//   ctrl_mask                 exception masks from the control word
//   status_word, top, busy    current status
//   fpu_int_req               registered unmasked-exception request
module fpu_status_word_unit
  import fpu_status_pkg::*;
#(
  parameter logic [2:0] TOP_RESET  = 3'd0,
  parameter bit         INT_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_start,
  input  logic             op_done,
  input  logic [EXC_W-1:0] exc_flags,
  input  logic             stack_fault,
  input  logic             stack_ovf,
  input  logic             cc_we,
  input  logic [3:0]       cc_in,
  input  logic             push,
  input  logic             pop,
  input  logic             fclex,
  input  logic             finit,
  input  logic             load_en,
  input  logic [15:0]      load_word,
  input  logic [EXC_W-1:0] ctrl_mask,
  output logic [15:0]      status_word,
  output logic [2:0]       top,
  output logic             busy,
  output logic             fpu_int_req
);

  logic             b_q, b_d;
  logic [3:0]       cc_q, cc_d;      // {C3,C2,C1,C0}
  logic [2:0]       top_q, top_d;
  logic             sf_q, sf_d;
  logic [EXC_W-1:0] exc_q, exc_d;
  logic             int_q, int_d;
  logic             es;
  logic [2:0]       top_step;
  fpu_status_t      sw;

  assign es = |(exc_q & ~ctrl_mask);

  // push and pop together cancel; arithmetic wraps at 3 bits.
  always_comb begin
    top_step = top_q;
    if (push && !pop) begin
      top_step = top_q - 3'd1;
    end else if (pop && !push) begin
      top_step = top_q + 3'd1;
    end
  end

  always_comb begin
    b_d   = b_q;
    cc_d  = cc_q;
    top_d = top_q;
    sf_d  = sf_q;
    exc_d = exc_q;
    int_d = es & INT_ENABLE;

    if (finit) begin
      b_d   = 1'b0;
      cc_d  = 4'b0000;
      top_d = TOP_RESET;
      sf_d  = 1'b0;
      exc_d = '0;
    end else if (load_en) begin
      // ES (bit 7) is derived, never stored.
      b_d   = load_word[SW_B];
      cc_d  = {load_word[SW_C3], load_word[SW_C2], load_word[SW_C1], load_word[SW_C0]};
      top_d = load_word[SW_TOP_LO +: 3];
      sf_d  = load_word[SW_SF];
      exc_d = load_word[EXC_W-1:0];
    end else if (fclex) begin
      sf_d  = 1'b0;
      exc_d = '0;
      top_d = top_step;
    end else begin
      top_d = top_step;
      if (cc_we) begin
        cc_d = cc_in;
      end
      if (op_done) begin
        exc_d = exc_q | exc_flags;
        if (stack_fault) begin
          sf_d         = 1'b1;
          exc_d[SW_IE] = 1'b1;
          cc_d[1]      = stack_ovf;  // overrides cc_in's C1
        end
      end
      // A new instruction starting in the completion cycle keeps the unit busy.
      if (instr_start) begin
        b_d = 1'b1;
      end else if (op_done) begin
        b_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_q   <= 1'b0;
      cc_q  <= 4'b0000;
      top_q <= TOP_RESET;
      sf_q  <= 1'b0;
      exc_q <= '0;
      int_q <= 1'b0;
    end else begin
      b_q   <= b_d;
      cc_q  <= cc_d;
      top_q <= top_d;
      sf_q  <= sf_d;
      exc_q <= exc_d;
      int_q <= int_d;
    end
  end

  always_comb begin
    sw.b   = b_q;
    sw.c3  = cc_q[3];
    sw.top = top_q;
    sw.c2  = cc_q[2];
    sw.c1  = cc_q[1];
    sw.c0  = cc_q[0];
    sw.es  = es;
    sw.sf  = sf_q;
    sw.exc = exc_q;
  end

  assign status_word = sw;
  assign top         = top_q;
  assign busy        = b_q;
  assign fpu_int_req = int_q;

endmodule

// File: tb/tb_fpu_status_word_unit.sv
// Bench for fpu_status_word_unit: directed scenarios followed by random traffic,
// all checked against a word-level reference model.
module tb_fpu_status_word_unit;

  localparam logic [2:0] TB_TOP_RESET = 3'd0;
  localparam bit         TB_INT_EN    = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_start, op_done, stack_fault, stack_ovf, cc_we;
  logic [5:0]  exc_flags, ctrl_mask;
  logic [3:0]  cc_in;
  logic        push, pop, fclex, finit, load_en;
  logic [15:0] load_word;
  logic [15:0] status_word;
  logic [2:0]  top;
  logic        busy, fpu_int_req;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  // Reference state: stored word with bit 7 unused, plus the interrupt flop.
  logic [15:0] m_sw;
  logic        m_int;

  always #5 clk = ~clk;

  fpu_status_word_unit #(
    .TOP_RESET  (TB_TOP_RESET),
    .INT_ENABLE (TB_INT_EN)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_start (instr_start),
    .op_done     (op_done),
    .exc_flags   (exc_flags),
    .stack_fault (stack_fault),
    .stack_ovf   (stack_ovf),
    .cc_we       (cc_we),
    .cc_in       (cc_in),
    .push        (push),
    .pop         (pop),
    .fclex       (fclex),
    .finit       (finit),
    .load_en     (load_en),
    .load_word   (load_word),
    .ctrl_mask   (ctrl_mask),
    .status_word (status_word),
    .top         (top),
    .busy        (busy),
    .fpu_int_req (fpu_int_req)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_es(input logic [15:0] w, input logic [5:0] mask);
    return |(w[5:0] & ~mask);
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] w, input logic [5:0] mask);
    logic [15:0] r;
    r    = w;
    r[7] = model_es(w, mask);
    return r;
  endfunction

  function automatic logic [15:0] model_reset_word();
    logic [15:0] r;
    r        = 16'h0000;
    r[13:11] = TB_TOP_RESET;
    return r;
  endfunction

  // Next-state of the reference word under the current inputs.
  function automatic logic [15:0] model_next(input logic [15:0] w);
    logic [15:0] r;
    int          t;
    r = w;
    t = int'(w[13:11]) + (pop ? 1 : 0) - (push ? 1 : 0);
    if (finit) begin
      r = model_reset_word();
    end else if (load_en) begin
      r    = load_word;
      r[7] = 1'b0;
    end else begin
      r[13:11] = 3'((t + 8) % 8);
      if (fclex) begin
        r[6:0] = 7'h00;
      end else begin
        if (cc_we) begin
          r[14] = cc_in[3];
          r[10] = cc_in[2];
          r[9]  = cc_in[1];
          r[8]  = cc_in[0];
        end
        if (op_done) begin
          r[5:0] = w[5:0] | exc_flags;
          if (stack_fault) begin
            r[6] = 1'b1;
            r[0] = 1'b1;
            r[9] = stack_ovf;
          end
        end
        if (instr_start)  r[15] = 1'b1;
        else if (op_done) r[15] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic idle_inputs();
    instr_start = 0; op_done = 0; exc_flags = '0; stack_fault = 0; stack_ovf = 0;
    cc_we = 0; cc_in = '0; push = 0; pop = 0; fclex = 0; finit = 0; load_en = 0;
    load_word = '0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".sw"}, status_word, model_word(m_sw, ctrl_mask));
    check_eq({tag, ".top"}, {13'd0, top}, {13'd0, m_sw[13:11]});
    check_eq({tag, ".busy"}, {15'd0, busy}, {15'd0, m_sw[15]});
    check_eq({tag, ".int"}, {15'd0, fpu_int_req}, {15'd0, m_int});
  endtask

  // One clock with the inputs currently driven; inputs return to idle afterwards.
  task automatic cycle(input string tag);
    logic [15:0] nxt;
    logic        nint;
    nxt  = model_next(m_sw);
    nint = TB_INT_EN & model_es(m_sw, ctrl_mask);
    @(posedge clk);
    #1;
    m_sw  = nxt;
    m_int = nint;
    idle_inputs();
    check_all(tag);
  endtask

  initial begin
    idle_inputs();
    ctrl_mask = 6'h3F;
    reset_n   = 1'b0;
    m_sw      = model_reset_word();
    m_int     = 1'b0;
    #12;
    check_all("reset");
    check_eq("reset_word", status_word, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // TOP wrap both ways and push+pop cancel.
    push = 1; cycle("push_wrap");
    check_eq("top_wrap7", {13'd0, status_word[13:11]}, 16'd7);
    pop = 1; cycle("pop1");
    pop = 1; cycle("pop2");
    check_eq("top_is1", {13'd0, top}, 16'd1);
    push = 1; pop = 1; cycle("pushpop");
    check_eq("top_stay1", {13'd0, top}, 16'd1);

    // Sticky flags, masked ES, then unmask ZE.
    op_done = 1; exc_flags = 6'b000100; cycle("op_ze");
    op_done = 1; exc_flags = 6'b000001; cycle("op_ie");
    check_eq("sticky", {10'd0, status_word[5:0]}, 16'h0005);
    check_eq("es_masked", {15'd0, status_word[7]}, 16'd0);
    ctrl_mask = 6'h3B;
    #1;
    check_eq("es_unmask_now", {15'd0, status_word[7]}, 16'd1);
    check_eq("int_not_yet", {15'd0, fpu_int_req}, 16'd0);
    cycle("int_rise");
    check_eq("int_up", {15'd0, fpu_int_req}, 16'd1);

    // Stack overflow fault overrides cc_in's C1.
    ctrl_mask = 6'h3F;
    op_done = 1; stack_fault = 1; stack_ovf = 1; cc_we = 1; cc_in = 4'b0000;
    cycle("stack_fault");
    check_eq("sf_ie_c1", {13'd0, status_word[6], status_word[0], status_word[9]}, 16'd7);
    check_eq("cc_others", {13'd0, status_word[14], status_word[10], status_word[8]}, 16'd0);

    // finit beats load_en; load_en alone loads everything but ES.
    finit = 1; load_en = 1; load_word = 16'hFFFF; cycle("finit_vs_load");
    check_eq("finit_word", status_word, {2'b00, TB_TOP_RESET, 11'd0});
    ctrl_mask = 6'h00;
    load_en = 1; load_word = 16'hFFFF; cycle("load_all");
    check_eq("load_word", status_word, 16'hFFFF);

    // fclex with push, starting from flags=3F, SF=1, TOP=3.
    load_en = 1; load_word = 16'h187F; cycle("load_pre_fclex");
    cycle("int_hold");
    fclex = 1; push = 1; cycle("fclex_push");
    check_eq("fclex_low", {9'd0, status_word[6:0]}, 16'd0);
    check_eq("fclex_top", {13'd0, top}, 16'd2);
    cycle("int_drop");
    check_eq("int_dropped", {15'd0, fpu_int_req}, 16'd0);

    // Async reset mid-operation with B=1 and all flags set.
    load_en = 1; load_word = 16'h803F; cycle("load_busy");
    cycle("int_busy");
    #2;
    reset_n = 1'b0;
    #1;
    m_sw  = model_reset_word();
    m_int = 1'b0;
    check_eq("async_reset_sw", status_word, 16'h0000);
    check_eq("async_reset_int", {15'd0, fpu_int_req}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      instr_start = ($urandom_range(0, 3) == 0);
      op_done     = ($urandom_range(0, 2) == 0);
      exc_flags   = ($urandom_range(0, 1) == 0) ? 6'($urandom) & 6'($urandom) : 6'h00;
      stack_fault = ($urandom_range(0, 5) == 0);
      stack_ovf   = 1'($urandom);
      cc_we       = ($urandom_range(0, 2) == 0);
      cc_in       = 4'($urandom);
      push        = 1'($urandom);
      pop         = 1'($urandom);
      fclex       = ($urandom_range(0, 15) == 0);
      finit       = ($urandom_range(0, 31) == 0);
      load_en     = ($urandom_range(0, 15) == 0);
      load_word   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ctrl_mask = 6'($urandom);
      #1;
      check_eq("rand_es", {15'd0, status_word[7]}, {15'd0, model_es(m_sw, ctrl_mask)});
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
